// File: rtl/cnn_acc_ci_tm.sv
// rtl/cnn_acc_ci_tm.sv - time-multiplexed input-channel accumulator with valid/ready output
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   i_soft_reset        synchronous clear of all state, highest priority
//   i_num_pass          passes per group minus 1, sampled on a group's first beat
//   i_in_valid/o_in_ready/i_in_lane_acc
//                       input beat handshake; lane k at [k*AK_BW +: AK_BW]
//   i_bias              (CNN_ACC_CI_BIAS_EN only) signed bias added once per group
//   o_ot_valid/i_ot_ready/o_ot_ci_acc
//                       result handshake; result held until i_ot_ready is seen
//   o_busy              group in progress or result pending
//
// Build option: define CNN_ACC_CI_BIAS_EN to add i_bias.
// Note: o_in_ready is combinational from i_ot_ready.

module cnn_acc_ci_tm #(
    parameter int LANES  = 4,
    parameter int AK_BW  = 20,
    parameter int PASS_W = 4,
    parameter int ACC_BW = 26
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_soft_reset,
    input  logic [PASS_W-1:0]      i_num_pass,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [LANES*AK_BW-1:0] i_in_lane_acc,
`ifdef CNN_ACC_CI_BIAS_EN
    input  logic [ACC_BW-1:0]      i_bias,
`endif
    output logic                   o_ot_valid,
    input  logic                   i_ot_ready,
    output logic [ACC_BW-1:0]      o_ot_ci_acc,
    output logic                   o_busy
);

    logic              stall;
    logic              accept;
    logic              beat_first;
    logic              beat_last;
    logic [PASS_W-1:0] in_cnt;
    logic [PASS_W-1:0] r_num_pass;
    logic [PASS_W-1:0] num_eff;
    logic [ACC_BW-1:0] lane_sum;
    logic [ACC_BW-1:0] s1_sum;
    logic              s1_valid;
    logic              s1_first;
    logic              s1_last;
    logic [ACC_BW-1:0] acc;
    logic [ACC_BW-1:0] acc_next;
    logic              s2_en;
`ifdef CNN_ACC_CI_BIAS_EN
    logic [ACC_BW-1:0] s1_bias;
`endif

    // Whole pipeline freezes while a result waits for the downstream stage.
    assign stall      = o_ot_valid & ~i_ot_ready;
    assign o_in_ready = ~stall;
    assign accept     = i_in_valid & ~stall;
    assign s2_en      = s1_valid & ~stall;

    // On a first beat the pass count being latched this cycle decides "last",
    // so a single-pass group is tagged first and last on the same beat.
    assign beat_first = (in_cnt == '0);
    assign num_eff    = beat_first ? i_num_pass : r_num_pass;
    assign beat_last  = (in_cnt == num_eff);

    assign o_busy = (in_cnt != '0) | s1_valid | o_ot_valid;

    always_comb begin
        lane_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_sum = lane_sum + {{(ACC_BW-AK_BW){i_in_lane_acc[k*AK_BW+AK_BW-1]}},
                                   i_in_lane_acc[k*AK_BW +: AK_BW]};
        end
    end

    always_comb begin
        acc_next = acc + s1_sum;
        if (s1_first) begin
`ifdef CNN_ACC_CI_BIAS_EN
            acc_next = s1_sum + s1_bias;
`else
            acc_next = s1_sum;
`endif
        end
    end

    // Input beat counter and per-group pass count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_cnt     <= '0;
            r_num_pass <= '0;
        end else if (i_soft_reset) begin
            in_cnt     <= '0;
            r_num_pass <= '0;
        end else if (accept) begin
            if (beat_first)
                r_num_pass <= i_num_pass;
            in_cnt <= beat_last ? '0 : in_cnt + 1'b1;
        end
    end

    // Stage 1: lane adder register, held during stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_sum   <= '0;
`ifdef CNN_ACC_CI_BIAS_EN
            s1_bias  <= '0;
`endif
        end else if (i_soft_reset) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_sum   <= '0;
`ifdef CNN_ACC_CI_BIAS_EN
            s1_bias  <= '0;
`endif
        end else if (!stall) begin
            s1_valid <= accept;
            if (accept) begin
                s1_first <= beat_first;
                s1_last  <= beat_last;
                s1_sum   <= lane_sum;
`ifdef CNN_ACC_CI_BIAS_EN
                s1_bias  <= i_bias;
`endif
            end
        end
    end

    // Stage 2: accumulator and output register. When not stalled, either the
    // output was empty or it is being handed off this cycle, so it reloads
    // from a new last beat or drops valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc         <= '0;
            o_ot_valid  <= 1'b0;
            o_ot_ci_acc <= '0;
        end else if (i_soft_reset) begin
            acc         <= '0;
            o_ot_valid  <= 1'b0;
            o_ot_ci_acc <= '0;
        end else if (!stall) begin
            if (s2_en)
                acc <= acc_next;
            o_ot_valid <= s2_en & s1_last;
            if (s2_en && s1_last)
                o_ot_ci_acc <= acc_next;
        end
    end

endmodule
